core101_shared_mem: RTL and testbench
=====================================

Name: core101_shared_mem

Overview:
- Unified, parametrised word memory shared by NUM_CH requesters over valid/ready request channels and per-channel response pulses.
- Replaces the separate instruction and data memories: channel 0 = instruction fetch, channel 1 = load/store, further channels spare (debug, DMA).
- Round-robin arbiter grants one request at a time; fixed, configurable access latency.

Parameters:
- XLEN, 32, data and address width in bits
- NUM_CH, 2, number of requester channels (>=1)
- DEPTH, 1024, memory size in XLEN-bit words (power of two)
- LATENCY, 1, cycles from request acceptance to response (>=1)

Ports:
- clock_in  in  1  single clock; all state updates on rising edge
- reset_in  in  1  asynchronous, active-high reset
- req_valid_in  in  NUM_CH  per-channel request valid
- req_write_in  in  NUM_CH  1 = write, 0 = read
- req_addr_in  in  NUM_CH*XLEN  byte addresses, channel i in bits [i*XLEN +: XLEN]
- req_wdata_in  in  NUM_CH*XLEN  write data, same packing
- req_ready_out  out  NUM_CH  one-hot grant; request i accepted when valid[i] && ready[i]
- resp_valid_out  out  NUM_CH  one-cycle response pulse on the accepted channel
- resp_data_out  out  NUM_CH*XLEN  read data (writes echo written data); valid only with resp_valid

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_ptr=0, latency counter=0, resp_valid_out=0, resp_data_out=0, req_ready_out=0. Memory contents are not cleared.
- Word index = addr[AW+1:2] with AW=clog2(DEPTH). addr[1:0] and bits above AW+1 are ignored; out-of-range addresses wrap.
- FSM IDLE:
  - req_ready_out is combinational: one-hot to the first channel with valid=1, searching from rr_ptr upward with wrap; all zero if no valid.
  - On acceptance: latch channel id, write flag, word index and wdata; rr_ptr <= (granted+1) mod NUM_CH.
  - Next state is RESP if LATENCY==1, else WAIT with count=LATENCY-1.
- FSM WAIT:
  - req_ready_out=0.
  - Counter decrements each cycle; on the cycle it reaches 1, the next state is RESP.
- Memory access happens on the edge entering RESP:
  - writes commit mem[index]<=wdata;
  - reads register mem[index] into the latched channel's resp_data slice.
- FSM RESP:
  - resp_valid_out[ch]=1 for exactly one cycle; req_ready_out=0; next state IDLE.
  - resp_data of other channels holds its previous value.
- Latency: a request accepted in cycle T gets its response pulse in cycle T+LATENCY. Throughput is one request per LATENCY+1 cycles.
- The requester must hold valid/write/addr/wdata stable until accepted. Deasserting valid before acceptance withdraws the request without error.
- Simultaneous requests: the lower channel index at or above rr_ptr wins; the loser keeps its ready low and is served next.
- Read-after-write to the same address from any channel returns the new data, because the write commits before the next acceptance.
- Reset mid-operation: the transaction is dropped, with no write commit and no response, if reset asserts before the RESP edge.
- NUM_CH==1: the arbiter degenerates; rr_ptr stays 0.

Optional Feature:
- Macro CORE101_SHARED_MEM_ERR_EN.
- Defined:
  - Adds port resp_err_out (out, NUM_CH), pulsing together with resp_valid_out.
  - Error is flagged when addr[1:0]!=0 or addr >= DEPTH*4.
  - An erroring write does not modify memory; an erroring read returns data 0.
- Undefined: no port; such addresses are silently truncated and wrap.

Test Plan:
- Reset, then ch1 writes 0xDEADBEEF to addr 0x10 -> ready[1]=1 in the acceptance cycle, resp_valid[1] pulses LATENCY cycles later; ch0 read of 0x10 then returns 0xDEADBEEF.
- ch0 and ch1 hold valid continuously with rr_ptr=0 -> grants alternate 0,1,0,1; each channel receives exactly one response per grant; no starvation over 20 requests.
- LATENCY=3: read accepted at cycle 5 -> resp_valid at cycle 8 only, ready low in cycles 6-8, next acceptance possible in cycle 9.
- Write to addr 4*DEPTH+8 (no ERR_EN) -> aliases word 2; read of addr 8 returns the written value. With ERR_EN: resp_err=1, word 2 unchanged, read data 0.
- Reset asserted during WAIT of a write to 0x20 -> no resp_valid, mem[0x20>>2] keeps its old value, state IDLE, rr_ptr 0.
- ch0 valid raised then dropped before grant while ch1 is being served -> no response ever issued on ch0.

Source files
------------

// File: rtl/core101_shared_mem.sv
// core101_shared_mem: unified word memory shared by NUM_CH requesters.
//
// Channel 0 is instruction fetch, channel 1 is load/store, any further channels are spare.
// A round-robin arbiter grants one request at a time. Each accepted request gets a single
// response pulse exactly LATENCY cycles after acceptance.
//
// Ports:
//   clock_in        single clock, rising edge
//   reset_in        asynchronous, active-high reset (memory contents are kept)
//   req_valid_in    per-channel request valid
//   req_write_in    per-channel write flag (1 = write, 0 = read)
//   req_addr_in     per-channel byte address, channel i in [i*XLEN +: XLEN]
//   req_wdata_in    per-channel write data, same packing
//   req_ready_out   one-hot grant, combinational, only while idle
//   resp_valid_out  one-cycle response pulse on the served channel
//   resp_data_out   read data (a write echoes its data), same packing
//   resp_err_out    only with CORE101_SHARED_MEM_ERR_EN: flags misaligned or out-of-range
//                   addresses, pulses together with resp_valid_out
//
// Optional feature macro: CORE101_SHARED_MEM_ERR_EN. Without it, bad addresses are silently
// truncated to a word index and wrap.
module core101_shared_mem #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [NUM_CH-1:0]        req_valid_in,
  input  logic [NUM_CH-1:0]        req_write_in,
  input  logic [NUM_CH*XLEN-1:0]   req_addr_in,
  input  logic [NUM_CH*XLEN-1:0]   req_wdata_in,
  output logic [NUM_CH-1:0]        req_ready_out,
  output logic [NUM_CH-1:0]        resp_valid_out,
`ifdef CORE101_SHARED_MEM_ERR_EN
  output logic [NUM_CH-1:0]        resp_err_out,
`endif
  output logic [NUM_CH*XLEN-1:0]   resp_data_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Wide enough to hold LATENCY-1.
  localparam int unsigned NW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef CORE101_SHARED_MEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q;
  logic [CW-1:0]      rr_ptr_q;
  logic [NW-1:0]      cnt_q;
  logic [CW-1:0]      ch_q;
  logic               wr_q;
  logic [AW-1:0]      idx_q;
  logic [XLEN-1:0]    wdata_q;
  logic               err_q;
  logic [NUM_CH-1:0]  resp_valid_q;
  logic [NUM_CH-1:0]  resp_err_q;
  logic [XLEN-1:0]    resp_data_q [NUM_CH];
  logic [XLEN-1:0]    mem_q [DEPTH];

  logic [XLEN-1:0]    addr_a  [NUM_CH];
  logic [XLEN-1:0]    wdata_a [NUM_CH];
  logic [NUM_CH-1:0]  err_a;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign addr_a[i]  = req_addr_in[i*XLEN +: XLEN];
    assign wdata_a[i] = req_wdata_in[i*XLEN +: XLEN];
    // Constant-folds away when the error feature is disabled.
    assign err_a[i]   = ErrEn && ((addr_a[i][1:0] != 2'b00) ||
                                  ((addr_a[i] >> (AW + 2)) != '0));
    assign resp_data_out[i*XLEN +: XLEN] = resp_data_q[i];
  end

  // Round-robin search: first pass covers channels at or above rr_ptr, second pass wraps.
  logic          gnt_found;
  logic [CW-1:0] gnt_idx;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!gnt_found && req_valid_in[j] && (CW'(j) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!gnt_found && req_valid_in[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(j);
      end
    end
  end

  always_comb begin
    req_ready_out = '0;
    if (state_q == StIdle && gnt_found) begin
      req_ready_out[gnt_idx] = 1'b1;
    end
  end

  // The access happens on the edge entering StResp. With LATENCY == 1 that is the acceptance
  // edge itself, so the live request is used instead of the latched copy.
  logic             enter_resp;
  logic [CW-1:0]    acc_ch;
  logic             acc_wr;
  logic [AW-1:0]    acc_idx;
  logic [XLEN-1:0]  acc_wdata;
  logic             acc_err;
  logic [XLEN-1:0]  acc_rdata;

  always_comb begin
    enter_resp = ((state_q == StIdle) && gnt_found && (LATENCY == 1)) ||
                 ((state_q == StWait) && (cnt_q == NW'(1)));
    acc_ch    = ch_q;
    acc_wr    = wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_err   = err_q;
    if (state_q == StIdle) begin
      acc_ch    = gnt_idx;
      acc_wr    = req_write_in[gnt_idx];
      acc_idx   = addr_a[gnt_idx][AW+1:2];
      acc_wdata = wdata_a[gnt_idx];
      acc_err   = err_a[gnt_idx];
    end
    acc_rdata = acc_err ? '0 : mem_q[acc_idx];
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        resp_data_q[i] <= '0;
      end
    end else begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            ch_q     <= gnt_idx;
            wr_q     <= req_write_in[gnt_idx];
            idx_q    <= addr_a[gnt_idx][AW+1:2];
            wdata_q  <= wdata_a[gnt_idx];
            err_q    <= err_a[gnt_idx];
            rr_ptr_q <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= NW'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == NW'(1)) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        resp_valid_q[acc_ch] <= 1'b1;
        resp_err_q[acc_ch]   <= acc_err;
        resp_data_q[acc_ch]  <= acc_wr ? acc_wdata : acc_rdata;
      end
    end
  end

  // No reset on the array; reset_in still blocks a commit so an interrupted write is dropped.
  always_ff @(posedge clock_in) begin
    if (enter_resp && acc_wr && !acc_err && !reset_in) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign resp_valid_out = resp_valid_q;

`ifdef CORE101_SHARED_MEM_ERR_EN
  assign resp_err_out = resp_err_q;
`else
  logic unused_resp_err;
  assign unused_resp_err = ^resp_err_q;
`endif

endmodule

// File: tb/tb_core101_shared_mem.sv
module tb_core101_shared_mem;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // LATENCY = 1 instance
  logic [1:0]  valid = '0, wr = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic [1:0]  ready, rvalid, err;
  logic [63:0] rdata;

  // LATENCY = 3 instance
  logic [1:0]  v3 = '0, w3 = '0;
  logic [63:0] a3 = '0, d3 = '0;
  logic [1:0]  rdy3, rv3, err3;
  logic [63:0] rd3;

  core101_shared_mem #(.XLEN(32), .NUM_CH(2), .DEPTH(1024), .LATENCY(1)) dut (
    .clock_in       (clk),
    .reset_in       (rst),
    .req_valid_in   (valid),
    .req_write_in   (wr),
    .req_addr_in    (addr),
    .req_wdata_in   (wdata),
    .req_ready_out  (ready),
    .resp_valid_out (rvalid),
`ifdef CORE101_SHARED_MEM_ERR_EN
    .resp_err_out   (err),
`endif
    .resp_data_out  (rdata)
  );

  core101_shared_mem #(.XLEN(32), .NUM_CH(2), .DEPTH(64), .LATENCY(3)) dut3 (
    .clock_in       (clk),
    .reset_in       (rst),
    .req_valid_in   (v3),
    .req_write_in   (w3),
    .req_addr_in    (a3),
    .req_wdata_in   (d3),
    .req_ready_out  (rdy3),
    .resp_valid_out (rv3),
`ifdef CORE101_SHARED_MEM_ERR_EN
    .resp_err_out   (err3),
`endif
    .resp_data_out  (rd3)
  );

`ifndef CORE101_SHARED_MEM_ERR_EN
  assign err  = '0;
  assign err3 = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the LATENCY=1 instance: returns the ready seen in the acceptance cycle and
  // the response seen in the following cycle.
  task automatic xact(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [1:0] g_rdy, output logic [1:0] g_rv,
                      output logic [31:0] g_data, output logic g_err);
    tick();
    valid = '0;
    valid[ch] = 1'b1;
    wr[ch] = w;
    addr[ch*32 +: 32] = a;
    wdata[ch*32 +: 32] = d;
    #1 g_rdy = ready;
    tick();
    valid = '0;
    #1;
    g_rv = rvalid;
    g_data = rdata[ch*32 +: 32];
    g_err = err[ch];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = '0;
    v3 = '0;
    #1;
    n_cmp++; if (ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", ready); end
    n_cmp++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
    n_cmp++; if (rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    tick();
    tick();
    n_cmp++; if (rv3 !== 2'b00 || rdy3 !== 2'b00) begin n_err++;
      $display("FAIL reset_l3: got rv=%b rdy=%b expected 00 00", rv3, rdy3); end
    n_cmp++; if (rd3 !== 64'h0) begin n_err++; $display("FAIL reset_l3_rdata: got %h expected 0", rd3); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [1:0] g_rdy, g_rv;
    logic [31:0] g_data;
    logic g_err;
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_rdy !== 2'b10) begin n_err++; $display("FAIL wr_ready: got %b expected 10", g_rdy); end
    n_cmp++; if (g_rv !== 2'b10) begin n_err++; $display("FAIL wr_rvalid: got %b expected 10", g_rv); end
    n_cmp++; if (g_data !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL wr_echo: got %h expected deadbeef", g_data); end
    xact(0, 1'b0, 32'h10, 32'h0, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_rdy !== 2'b01) begin n_err++; $display("FAIL rd_ready: got %b expected 01", g_rdy); end
    n_cmp++; if (g_rv !== 2'b01) begin n_err++; $display("FAIL rd_rvalid: got %b expected 01", g_rv); end
    n_cmp++; if (g_data !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL rd_data: got %h expected deadbeef", g_data); end
    n_cmp++; if (rdata[63:32] !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL rd_hold_ch1: got %h expected deadbeef", rdata[63:32]); end
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    logic [1:0] exp;
    test_reset();
    tick();
    valid = 2'b11;
    wr = 2'b00;
    addr = {32'h10, 32'h10};
    #1;
    for (int i = 0; i < 20; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (ready !== exp) begin n_err++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, ready, exp); end
      tick();
      n_cmp++; if (rvalid !== exp || ready !== 2'b00) begin n_err++;
        $display("FAIL rr_resp[%0d]: got rv=%b rdy=%b expected %b 00", i, rvalid, ready, exp); end
      n0 += int'(rvalid[0]);
      n1 += int'(rvalid[1]);
      tick();
    end
    valid = '0;
    n_cmp++; if (n0 != 10 || n1 != 10) begin n_err++;
      $display("FAIL rr_counts: got %0d/%0d expected 10/10", n0, n1); end
  endtask

  task automatic test_wrap();
    logic [1:0] g_rdy, g_rv;
    logic [31:0] g_data;
    logic g_err;
`ifdef CORE101_SHARED_MEM_ERR_EN
    xact(0, 1'b1, 32'h8, 32'hCAFEF00D, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_err !== 1'b0) begin n_err++; $display("FAIL err_ok: got %b expected 0", g_err); end
    xact(1, 1'b1, 32'h1008, 32'h12345678, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_rv !== 2'b10 || g_err !== 1'b1) begin n_err++;
      $display("FAIL err_wr: got rv=%b err=%b expected 10 1", g_rv, g_err); end
    xact(0, 1'b0, 32'h8, 32'h0, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_data !== 32'hCAFEF00D) begin n_err++;
      $display("FAIL err_word2_kept: got %h expected cafef00d", g_data); end
    xact(0, 1'b0, 32'h1008, 32'h0, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_data !== 32'h0 || g_err !== 1'b1) begin n_err++;
      $display("FAIL err_rd: got %h err=%b expected 0 1", g_data, g_err); end
    xact(1, 1'b0, 32'hA, 32'h0, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_data !== 32'h0 || g_err !== 1'b1) begin n_err++;
      $display("FAIL err_misalign: got %h err=%b expected 0 1", g_data, g_err); end
`else
    xact(1, 1'b1, 32'h1008, 32'h12345678, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_rv !== 2'b10) begin n_err++; $display("FAIL wrap_wr: got %b expected 10", g_rv); end
    xact(0, 1'b0, 32'h8, 32'h0, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_data !== 32'h12345678) begin n_err++;
      $display("FAIL wrap_rd: got %h expected 12345678", g_data); end
    xact(1, 1'b0, 32'hB, 32'h0, g_rdy, g_rv, g_data, g_err);
    n_cmp++; if (g_data !== 32'h12345678) begin n_err++;
      $display("FAIL wrap_misalign: got %h expected 12345678", g_data); end
`endif
  endtask

  task automatic test_latency3();
    tick();
    v3 = 2'b10; w3 = 2'b10; a3[63:32] = 32'h10; d3[63:32] = 32'hA5A50001;
    #1;
    n_cmp++; if (rdy3 !== 2'b10 || rv3 !== 2'b00) begin n_err++;
      $display("FAIL l3_accept: got rdy=%b rv=%b expected 10 00", rdy3, rv3); end
    tick();
    v3 = 2'b01; w3 = 2'b00; a3[31:0] = 32'h10;
    #1;
    for (int c = 1; c <= 2; c++) begin
      n_cmp++; if (rdy3 !== 2'b00 || rv3 !== 2'b00) begin n_err++;
        $display("FAIL l3_wait[%0d]: got rdy=%b rv=%b expected 00 00", c, rdy3, rv3); end
      tick();
    end
    n_cmp++; if (rv3 !== 2'b10 || rdy3 !== 2'b00 || rd3[63:32] !== 32'hA5A50001) begin n_err++;
      $display("FAIL l3_resp: got rv=%b rdy=%b d=%h expected 10 00 a5a50001", rv3, rdy3, rd3[63:32]);
    end
    tick();
    n_cmp++; if (rdy3 !== 2'b01 || rv3 !== 2'b00) begin n_err++;
      $display("FAIL l3_next_accept: got rdy=%b rv=%b expected 01 00", rdy3, rv3); end
    tick();
    v3 = '0;
    tick();
    n_cmp++; if (rv3 !== 2'b00) begin n_err++; $display("FAIL l3_early: got %b expected 00", rv3); end
    tick();
    n_cmp++; if (rv3 !== 2'b01 || rd3[31:0] !== 32'hA5A50001) begin n_err++;
      $display("FAIL l3_read: got rv=%b d=%h expected 01 a5a50001", rv3, rd3[31:0]); end
  endtask

  task automatic test_reset_mid();
    tick();
    v3 = 2'b01; w3 = 2'b01; a3[31:0] = 32'h20; d3[31:0] = 32'h1111;
    #1;
    n_cmp++; if (rdy3 !== 2'b01) begin n_err++; $display("FAIL rm_pre_accept: got %b expected 01", rdy3); end
    tick();
    v3 = '0;
    tick();
    tick();
    n_cmp++; if (rv3 !== 2'b01) begin n_err++; $display("FAIL rm_pre_resp: got %b expected 01", rv3); end
    tick();
    v3 = 2'b01; w3 = 2'b01; d3[31:0] = 32'h2222;
    #1;
    n_cmp++; if (rdy3 !== 2'b01) begin n_err++; $display("FAIL rm_accept: got %b expected 01", rdy3); end
    tick();
    v3 = '0;
    rst = 1'b1;
    #1;
    n_cmp++; if (rv3 !== 2'b00 || rdy3 !== 2'b00) begin n_err++;
      $display("FAIL rm_in_reset: got rv=%b rdy=%b expected 00 00", rv3, rdy3); end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (rv3 !== 2'b00) begin n_err++; $display("FAIL rm_no_resp[%0d]: got %b expected 00", c, rv3); end
    end
    v3 = 2'b11; w3 = 2'b00; a3 = {32'h20, 32'h20};
    #1;
    n_cmp++; if (rdy3 !== 2'b01) begin n_err++; $display("FAIL rm_rr_ptr: got %b expected 01", rdy3); end
    tick();
    tick();
    tick();
    n_cmp++; if (rv3 !== 2'b01 || rd3[31:0] !== 32'h1111) begin n_err++;
      $display("FAIL rm_old_data: got rv=%b d=%h expected 01 00001111", rv3, rd3[31:0]); end
    v3 = '0;
  endtask

  task automatic test_withdraw();
    int seen = 0;
    tick();
    v3 = 2'b10; w3 = 2'b10; a3[63:32] = 32'h30; d3[63:32] = 32'h3333;
    #1;
    n_cmp++; if (rdy3 !== 2'b10) begin n_err++; $display("FAIL wd_accept: got %b expected 10", rdy3); end
    tick();
    v3 = 2'b01; w3 = 2'b00; a3[31:0] = 32'h30;
    #1;
    n_cmp++; if (rdy3 !== 2'b00) begin n_err++; $display("FAIL wd_ready_low: got %b expected 00", rdy3); end
    tick();
    tick();
    v3 = '0;
    #1;
    n_cmp++; if (rv3 !== 2'b10) begin n_err++; $display("FAIL wd_ch1_resp: got %b expected 10", rv3); end
    for (int c = 0; c < 6; c++) begin
      tick();
      seen += int'(rv3[0]);
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL wd_no_ch0: got %0d responses expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_wrap();
    test_latency3();
    test_reset_mid();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
